ahb_slave_if_p: RTL and testbench

//  Parametrised AHB slave front-end of the AHB-to-APB bridge. Decodes NUM_SLV equal APB regions,

---
 rtl/ahb_slave_if_p.sv | 176 +++++++++++++++++
 tb/tb_ahb_slave_if_p.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_if_p.sv
// ahb_slave_if_p: AHB slave front-end of the AHB-to-APB bridge.
// Decodes NUM_SLV equal APB regions, tracks the AHB transfer state and burst beat
// count, and pipelines address/data two stages deep for the APB FSM.
// Optional feature: define AHB_ERR_RESP_EN to answer unmapped or oversized transfers
// with a two-cycle AHB ERROR response; otherwise Hreadyout/Hresp are tied to OKAY.
module ahb_slave_if_p #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] SLV_SIZE  = 32'h0400_0000,
    parameter int unsigned       BEAT_W    = 4
) (
    input  logic               Hclk,
    input  logic               Hreset,
    input  logic               Hreadyin,
    input  logic [1:0]         Htrans,
    input  logic               Hwrite,
    input  logic [2:0]         Hsize,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [DATA_W-1:0]  Hwdata,
    output logic               Valid,
    output logic [NUM_SLV-1:0] Tempselx,
    output logic [ADDR_W-1:0]  Haddr1,
    output logic [ADDR_W-1:0]  Haddr2,
    output logic [DATA_W-1:0]  Hdata1,
    output logic [DATA_W-1:0]  Hdata2,
    output logic               Hwrite_reg,
    output logic [BEAT_W-1:0]  Beat_cnt,
    output logic               Hreadyout,
    output logic [1:0]         Hresp
);

    // AHB HTRANS encodings
    localparam logic [1:0] TrIdle   = 2'b00;
    localparam logic [1:0] TrBusy   = 2'b01;
    localparam logic [1:0] TrNonseq = 2'b10;
    localparam logic [1:0] TrSeq    = 2'b11;

    // Largest legal HSIZE is the full data-bus width
    localparam int unsigned MaxSize = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        StIdle,
        StBusy,
        StNonseq,
        StSeq,
        StErr1,
        StErr2
    } state_e;

    // One extra bit so the upper bound of the top region cannot wrap to zero
    typedef logic [ADDR_W:0] addr_ext_t;

    localparam addr_ext_t BaseExt = addr_ext_t'(BASE_ADDR);
    localparam addr_ext_t SizeExt = addr_ext_t'(SLV_SIZE);

    state_e              state_q, state_d;
    logic   [BEAT_W-1:0] beat_d;
    logic                in_err1;
    logic                accept;
    logic                mapped;
    logic                size_ok;
    addr_ext_t           haddr_ext;

    assign haddr_ext = {1'b0, Haddr};

    // Region decode: one comparator pair per APB slave window
    for (genvar i = 0; i < NUM_SLV; i++) begin : g_region
        localparam addr_ext_t Lo = BaseExt + addr_ext_t'(i) * SizeExt;
        localparam addr_ext_t Hi = Lo + SizeExt;
        assign Tempselx[i] = (haddr_ext >= Lo) && (haddr_ext < Hi);
    end

`ifdef AHB_ERR_RESP_EN
    logic bad_xfer;

    // The first error cycle stalls the bus, so nothing new can be accepted in it
    assign in_err1  = (state_q == StErr1);
    assign bad_xfer = accept & ~(mapped & size_ok);
`else
    assign in_err1  = 1'b0;
`endif

    assign accept  = Hreadyin & Htrans[1] & ~in_err1;
    assign mapped  = |Tempselx;
    assign size_ok = (Hsize <= 3'(MaxSize));
    assign Valid   = accept & mapped & size_ok;

    // Next transfer state and beat index from HTRANS
    always_comb begin
        state_d = state_q;
        beat_d  = Beat_cnt;
        if (in_err1) begin
            state_d = StErr2;
        end else if (Hreadyin) begin
            unique case (Htrans)
                TrIdle: begin
                    state_d = StIdle;
                    beat_d  = '0;
                end
                TrBusy: begin
                    state_d = StBusy;
                end
                TrNonseq: begin
                    state_d = StNonseq;
                    beat_d  = '0;
                end
                TrSeq: begin
                    // A SEQ with no burst in progress is really the first beat
                    if (state_q == StIdle) begin
                        state_d = StNonseq;
                        beat_d  = '0;
                    end else begin
                        state_d = StSeq;
                        beat_d  = (Beat_cnt == '1) ? Beat_cnt : Beat_cnt + BEAT_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
`ifdef AHB_ERR_RESP_EN
            if (bad_xfer) begin
                state_d = StErr1;
                beat_d  = '0;
            end
`endif
        end
    end

    // Transfer state and beat counter registers
    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            state_q  <= StIdle;
            Beat_cnt <= '0;
        end else begin
            state_q  <= state_d;
            Beat_cnt <= beat_d;
        end
    end

    // Two-stage address/data pipeline, frozen while the bus is waited
    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            Haddr1 <= '0;
            Haddr2 <= '0;
            Hdata1 <= '0;
            Hdata2 <= '0;
        end else if (Hreadyin) begin
            Haddr1 <= Haddr;
            Haddr2 <= Haddr1;
            Hdata1 <= Hwdata;
            Hdata2 <= Hdata1;
        end
    end

    // Direction is captured only for transfers the slave actually accepts
    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            Hwrite_reg <= 1'b0;
        end else if (accept) begin
            Hwrite_reg <= Hwrite;
        end
    end

`ifdef AHB_ERR_RESP_EN
    // ERROR response: stall in the first cycle, complete in the second
    assign Hreadyout = (state_q != StErr1);
    assign Hresp     = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
`else
    assign Hreadyout = 1'b1;
    assign Hresp     = 2'b00;
`endif

endmodule

// File: tb/tb_ahb_slave_if_p.sv
// tb_ahb_slave_if_p: scoreboard bench for ahb_slave_if_p (default parameters).
// Expectations follow AHB_ERR_RESP_EN when it is defined for the build.
module tb_ahb_slave_if_p;

    logic        Hclk;
    logic        Hreset;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Valid;
    logic [2:0]  Tempselx;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hdata1;
    logic [31:0] Hdata2;
    logic        Hwrite_reg;
    logic [3:0]  Beat_cnt;
    logic        Hreadyout;
    logic [1:0]  Hresp;

    ahb_slave_if_p #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NUM_SLV  (3),
        .BASE_ADDR(32'h8000_0000),
        .SLV_SIZE (32'h0400_0000),
        .BEAT_W   (4)
    ) dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Hwrite    (Hwrite),
        .Hsize     (Hsize),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Valid     (Valid),
        .Tempselx  (Tempselx),
        .Haddr1    (Haddr1),
        .Haddr2    (Haddr2),
        .Hdata1    (Hdata1),
        .Hdata2    (Hdata2),
        .Hwrite_reg(Hwrite_reg),
        .Beat_cnt  (Beat_cnt),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp)
    );

    localparam logic [1:0] TIDLE = 2'b00, TBUSY = 2'b01, TNSEQ = 2'b10, TSEQ = 2'b11;

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for one clock cycle
    typedef struct packed {
        logic [31:0] id;
        logic        valid;
        logic [2:0]  sel;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        wr;
        logic [3:0]  beat;
        logic        rdy;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   step_id = 0;

    // Reference state: 0 idle, 1 busy, 2 nonseq, 3 seq, 4 err1, 5 err2
    int          m_st;
    logic [3:0]  m_beat;
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_wr;

    task automatic model_reset();
        m_st = 0; m_beat = '0; m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_wr = 1'b0;
    endtask

    // Region select computed as an offset division over the 3 windows
    function automatic logic [2:0] ref_sel(input logic [31:0] a);
        logic [63:0] off;
        logic [2:0]  s;
        s = '0;
        if (a >= 32'h8000_0000) begin
            off = 64'(a) - 64'h8000_0000;
            if (off < 64'h0C00_0000) s[int'(off / 64'h0400_0000)] = 1'b1;
        end
        return s;
    endfunction

    task automatic step(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] ad, input logic [31:0] wd, input logic rdy,
                        input int lit_valid = -1, input int lit_sel = -1);
        exp_t       e;
        logic [2:0] sel;
        logic       legal, acc, err1;
        Htrans = tr; Hwrite = wr; Hsize = sz; Haddr = ad; Hwdata = wd; Hreadyin = rdy;
        sel   = ref_sel(ad);
        legal = (sz <= 3'd2);
        err1  = (m_st == 4);
        acc   = rdy && tr[1] && !err1;
        e.id = step_id; e.valid = acc && (sel != 3'b000) && legal; e.sel = sel;
        e.a1 = m_a1; e.a2 = m_a2; e.d1 = m_d1; e.d2 = m_d2; e.wr = m_wr; e.beat = m_beat;
`ifdef AHB_ERR_RESP_EN
        e.rdy  = (m_st != 4);
        e.resp = (m_st == 4 || m_st == 5) ? 2'b01 : 2'b00;
`else
        e.rdy  = 1'b1;
        e.resp = 2'b00;
`endif
        sb_q.push_back(e);
        // Advance the reference to the state after the coming edge
        if (rdy) begin
            m_a2 = m_a1; m_a1 = ad; m_d2 = m_d1; m_d1 = wd;
        end
        if (acc) m_wr = wr;
        if (err1) begin
            m_st = 5;
        end else if (rdy) begin
            case (tr)
                TIDLE: begin m_st = 0; m_beat = '0; end
                TBUSY: m_st = 1;
                TNSEQ: begin m_st = 2; m_beat = '0; end
                default: begin
                    if (m_st == 0) begin
                        m_st = 2; m_beat = '0;
                    end else begin
                        m_st = 3;
                        if (m_beat != 4'hF) m_beat = m_beat + 4'd1;
                    end
                end
            endcase
`ifdef AHB_ERR_RESP_EN
            if (acc && !((sel != 3'b000) && legal)) begin
                m_st = 4; m_beat = '0;
            end
`endif
        end
        #3;
        if (lit_valid >= 0) check_eq($sformatf("s%0d.lit_valid", step_id), 64'(Valid), 64'(lit_valid));
        if (lit_sel >= 0) check_eq($sformatf("s%0d.lit_sel", step_id), 64'(Tempselx), 64'(lit_sel));
        @(posedge Hclk);
        #1;
        step_id++;
    endtask

    // Pop one expectation per cycle, mid-cycle
    always @(negedge Hclk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check_eq($sformatf("s%0d.Valid", mon_e.id), 64'(Valid), 64'(mon_e.valid));
            check_eq($sformatf("s%0d.Tempselx", mon_e.id), 64'(Tempselx), 64'(mon_e.sel));
            check_eq($sformatf("s%0d.Haddr1", mon_e.id), 64'(Haddr1), 64'(mon_e.a1));
            check_eq($sformatf("s%0d.Haddr2", mon_e.id), 64'(Haddr2), 64'(mon_e.a2));
            check_eq($sformatf("s%0d.Hdata1", mon_e.id), 64'(Hdata1), 64'(mon_e.d1));
            check_eq($sformatf("s%0d.Hdata2", mon_e.id), 64'(Hdata2), 64'(mon_e.d2));
            check_eq($sformatf("s%0d.Hwrite_reg", mon_e.id), 64'(Hwrite_reg), 64'(mon_e.wr));
            check_eq($sformatf("s%0d.Beat_cnt", mon_e.id), 64'(Beat_cnt), 64'(mon_e.beat));
            check_eq($sformatf("s%0d.Hreadyout", mon_e.id), 64'(Hreadyout), 64'(mon_e.rdy));
            check_eq($sformatf("s%0d.Hresp", mon_e.id), 64'(Hresp), 64'(mon_e.resp));
        end
    end

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".Haddr1"}, 64'(Haddr1), 64'h0);
        check_eq({tag, ".Haddr2"}, 64'(Haddr2), 64'h0);
        check_eq({tag, ".Hdata1"}, 64'(Hdata1), 64'h0);
        check_eq({tag, ".Hdata2"}, 64'(Hdata2), 64'h0);
        check_eq({tag, ".Hwrite_reg"}, 64'(Hwrite_reg), 64'h0);
        check_eq({tag, ".Beat_cnt"}, 64'(Beat_cnt), 64'h0);
        check_eq({tag, ".Hreadyout"}, 64'(Hreadyout), 64'h1);
        check_eq({tag, ".Hresp"}, 64'(Hresp), 64'h0);
    endtask

    // After a bad transfer: ERR1, ERR2, OKAY when the error response is built in
    task automatic check_resp(input string tag, input int phase);
        logic       rdy_x;
        logic [1:0] resp_x;
`ifdef AHB_ERR_RESP_EN
        rdy_x  = (phase != 1);
        resp_x = (phase == 1 || phase == 2) ? 2'b01 : 2'b00;
`else
        rdy_x  = 1'b1;
        resp_x = 2'b00;
`endif
        check_eq({tag, ".Hreadyout"}, 64'(Hreadyout), 64'(rdy_x));
        check_eq({tag, ".Hresp"}, 64'(Hresp), 64'(resp_x));
    endtask

    initial begin
        Hreset = 1'b0; Hreadyin = 1'b0; Htrans = TIDLE; Hwrite = 1'b0; Hsize = 3'd0;
        Haddr = '0; Hwdata = '0;
        model_reset();
        #2;
        check_reset_state("por");
        #1 Hreset = 1'b1;
        @(posedge Hclk);
        #1;

        // Single NONSEQ write into region 1
        step(TNSEQ, 1'b1, 3'd2, 32'h8400_0010, 32'hA5A5_0001, 1'b1, 1, 3'b010);
        check_eq("t2.Haddr1", 64'(Haddr1), 64'h8400_0010);
        check_eq("t2.Hwrite_reg", 64'(Hwrite_reg), 64'h1);
        step(TIDLE, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000, 1'b1);
        check_eq("t2.Haddr2", 64'(Haddr2), 64'h8400_0010);
        check_eq("t2.Hdata2", 64'(Hdata2), 64'hA5A5_0001);

        // Burst with two wait states, then run the beat counter into saturation
        step(TNSEQ, 1'b1, 3'd2, 32'h8000_1000, 32'hD000_0000, 1'b1, 1, 3'b001);
        check_eq("t3.beat0", 64'(Beat_cnt), 64'd0);
        step(TSEQ, 1'b1, 3'd2, 32'h8000_1004, 32'hD000_0001, 1'b1, 1, 3'b001);
        check_eq("t3.beat1", 64'(Beat_cnt), 64'd1);
        for (int i = 0; i < 2; i++) begin
            step(TSEQ, 1'b1, 3'd2, 32'h8000_1008, 32'hD000_0F00 + 32'(i), 1'b0, 0, 3'b001);
            check_eq("t3.hold_Haddr1", 64'(Haddr1), 64'h8000_1004);
            check_eq("t3.hold_Hdata1", 64'(Hdata1), 64'hD000_0001);
            check_eq("t3.hold_beat", 64'(Beat_cnt), 64'd1);
        end
        step(TBUSY, 1'b1, 3'd2, 32'h8000_1008, 32'hD000_0002, 1'b1, 0, 3'b001);
        check_eq("t3.busy_beat", 64'(Beat_cnt), 64'd1);
        step(TSEQ, 1'b1, 3'd2, 32'h8000_1008, 32'hD000_0003, 1'b1, 1, 3'b001);
        check_eq("t3.beat2", 64'(Beat_cnt), 64'd2);
        step(TSEQ, 1'b1, 3'd2, 32'h8000_100C, 32'hD000_0004, 1'b1, 1, 3'b001);
        check_eq("t3.beat3", 64'(Beat_cnt), 64'd3);
        for (int i = 0; i < 14; i++)
            step(TSEQ, 1'b1, 3'd2, 32'h8000_1010 + 32'(4 * i), $urandom, 1'b1);
        check_eq("t3.beat_sat", 64'(Beat_cnt), 64'd15);
        step(TIDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        check_eq("t3.idle_clr", 64'(Beat_cnt), 64'd0);

        // Region boundaries
        step(TNSEQ, 1'b0, 3'd0, 32'h8BFF_FFFF, 32'h0, 1'b1, 1, 3'b100);
        step(TNSEQ, 1'b0, 3'd0, 32'h8C00_0000, 32'h0, 1'b1, 0, 3'b000);
        step(TNSEQ, 1'b0, 3'd0, 32'h7FFF_FFFF, 32'h0, 1'b1, 0, 3'b000);
        step(TNSEQ, 1'b0, 3'd0, 32'h8000_0000, 32'h0, 1'b1, 1, 3'b001);
        step(TNSEQ, 1'b0, 3'd1, 32'h83FF_FFFF, 32'h0, 1'b1, 1, 3'b001);
        step(TNSEQ, 1'b0, 3'd2, 32'h8800_0000, 32'h0, 1'b1, 1, 3'b100);
        step(TIDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

        // Unmapped transfer
        step(TNSEQ, 1'b1, 3'd2, 32'h9000_0000, 32'h1111_2222, 1'b1, 0, 3'b000);
        check_resp("t5.c1", 1);
        step(TIDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        check_resp("t5.c2", 2);
        step(TIDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        check_resp("t5.c3", 0);

        // Oversized transfer, then a good one issued in the second error cycle
        step(TNSEQ, 1'b1, 3'd3, 32'h8000_0100, 32'h3333_4444, 1'b1, 0, 3'b001);
        check_resp("t6.c1", 1);
        step(TIDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        check_resp("t6.c2", 2);
        step(TNSEQ, 1'b1, 3'd2, 32'h8000_0200, 32'h5555_6666, 1'b1, 1, 3'b001);
        check_resp("t6.c3", 0);
        step(TIDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

        // Random burst traffic, then asynchronous reset in mid-cycle
        for (int i = 0; i < 6; i++) begin
            Htrans   = (i == 0) ? TNSEQ : TSEQ;
            Hwrite   = 1'b1;
            Hsize    = 3'($urandom_range(2));
            Haddr    = 32'h8000_0000 + ($urandom & 32'h07FF_FFFC);
            Hwdata   = $urandom | 32'h1;
            Hreadyin = 1'b1;
            @(posedge Hclk);
            #1;
        end
        @(negedge Hclk);
        #2 Hreset = 1'b0;
        #1 check_reset_state("t1.async");
        @(posedge Hclk);
        #1 check_reset_state("t1.held");
        Hreadyin = 1'b0; Htrans = TIDLE;
        @(negedge Hclk);
        Hreset = 1'b1;
        model_reset();
        @(posedge Hclk);
        #1;
        step(TSEQ, 1'b0, 3'd2, 32'h8000_0300, 32'h7777_0000, 1'b1, 1, 3'b001);
        check_eq("t1.restart_beat", 64'(Beat_cnt), 64'd0);
        step(TSEQ, 1'b0, 3'd2, 32'h8000_0304, 32'h7777_0001, 1'b1, 1, 3'b001);
        check_eq("t1.second_beat", 64'(Beat_cnt), 64'd1);
        step(TIDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

        @(negedge Hclk);
        check_eq("sb.drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
